// File: rtl/pedo_scheduler_if.sv
// Bundle of request, register-file, evaluator and status signals for
// pedo_scheduler. The slave modport is the scheduler's view. The master
// modport is the view of the surrounding system: requesters, register file,
// evaluator and status consumer.
//
// Handshake rule for both request channels (smp_*, wt_*): the requester raises
// valid together with its data and holds both stable until a rising edge at
// which valid and ready are both high; that edge is the accept edge. Ready may
// drop at any time while valid is held, and the request simply waits.
interface pedo_scheduler_if #(
  parameter int CNT_W = 8
);
  // sample request
  logic             smp_valid;
  logic             smp_ready;
  logic [7:0]       smp_a;
  logic [7:0]       smp_b;
  // weight-update request
  logic             wt_valid;
  logic             wt_ready;
  logic             wt_dual;
  logic [2:0]       wt_addr1;
  logic [2:0]       wt_addr2;
  logic [7:0]       wt_data1;
  logic [7:0]       wt_data2;
  // step counter control
  logic             clr_steps;
  // weight register-file write port
  logic             rf_we;
  logic [2:0]       rf_addr;
  logic [7:0]       rf_data;
  // step evaluator
  logic             ex_start;
  logic [7:0]       ex_a;
  logic [7:0]       ex_b;
  logic             ex_step;
  // status
  logic [CNT_W-1:0] total_steps;
  logic             busy;
  logic [2:0]       dbg_state;

  modport slave (
    input  smp_valid, smp_a, smp_b,
    input  wt_valid, wt_dual, wt_addr1, wt_addr2, wt_data1, wt_data2,
    input  clr_steps, ex_step,
    output smp_ready, wt_ready,
    output rf_we, rf_addr, rf_data,
    output ex_start, ex_a, ex_b,
    output total_steps, busy, dbg_state
  );

  modport master (
    output smp_valid, smp_a, smp_b,
    output wt_valid, wt_dual, wt_addr1, wt_addr2, wt_data1, wt_data2,
    output clr_steps, ex_step,
    input  smp_ready, wt_ready,
    input  rf_we, rf_addr, rf_data,
    input  ex_start, ex_a, ex_b,
    input  total_steps, busy, dbg_state
  );
endinterface

// File: rtl/pedo_scheduler.sv
// Pedometer scheduler. It arbitrates between weight-update requests and
// accelerometer sample requests.
//
// Weight updates write one or two address/data pairs into the weight register
// file, one pair per cycle. Addresses 6 and 7 do not exist, so the write strobe
// is suppressed in those cycles.
//
// A sample launches the step evaluator. The scheduler then waits EVAL_LAT
// cycles and adds the evaluator's decision to total_steps.
//
// Weight updates win when both request types arrive in the same cycle.
//
// Optional feature: define PEDO_STEP_SAT_EN to make total_steps saturate at
// its maximum value. Without it the counter wraps to zero.
//
// EVAL_LAT must lie in 1..15 because the wait counter is 4 bits wide.
module pedo_scheduler #(
  parameter int CNT_W    = 8,
  parameter int EVAL_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  pedo_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR1   = 3'd1,
    WR2   = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    ACC   = 3'd5
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(EVAL_LAT);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       addr1_q, addr1_d;
  logic [2:0]       addr2_q, addr2_d;
  logic [7:0]       data1_q, data1_d;
  logic [7:0]       data2_q, data2_d;
  logic             dual_q, dual_d;
  logic [7:0]       ex_a_q, ex_a_d;
  logic [7:0]       ex_b_q, ex_b_d;
  logic [CNT_W-1:0] total_q, total_d;

  logic             idle;
  logic             rf_we;
  logic [2:0]       rf_addr;
  logic [7:0]       rf_data;

  assign idle = (state_q == IDLE);

  // Next-state logic and request latching; a weight request pre-empts a sample
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    data1_d = data1_q;
    data2_d = data2_q;
    dual_d  = dual_q;
    ex_a_d  = ex_a_q;
    ex_b_d  = ex_b_q;
    case (state_q)
      IDLE: begin
        if (bus.wt_valid) begin
          addr1_d = bus.wt_addr1;
          addr2_d = bus.wt_addr2;
          data1_d = bus.wt_data1;
          data2_d = bus.wt_data2;
          dual_d  = bus.wt_dual;
          state_d = WR1;
        end else if (bus.smp_valid) begin
          ex_a_d  = bus.smp_a;
          ex_b_d  = bus.smp_b;
          state_d = START;
        end
      end
      WR1:   state_d = dual_q ? WR2 : IDLE;
      WR2:   state_d = IDLE;
      START: begin
        cnt_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        // WAIT lasts EVAL_LAT cycles. The <= also guards against a zero count.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ACC;
        end
      end
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Step accumulator: ex_step is only meaningful in ACC, and a clear overrides it
  always_comb begin
    total_d = total_q;
    if ((state_q == ACC) && bus.ex_step) begin
`ifdef PEDO_STEP_SAT_EN
      if (total_q != {CNT_W{1'b1}}) begin
        total_d = total_q + CNT_W'(1);
      end
`else
      total_d = total_q + CNT_W'(1);
`endif
    end
    if (bus.clr_steps) begin
      total_d = '0;
    end
  end

  // Register-file write port: drives only in WR1/WR2, and skips addresses 6 and 7
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = 3'd0;
    rf_data = 8'd0;
    case (state_q)
      WR1: begin
        rf_we   = (addr1_q < 3'd6);
        rf_addr = addr1_q;
        rf_data = data1_q;
      end
      WR2: begin
        rf_we   = (addr2_q < 3'd6);
        rf_addr = addr2_q;
        rf_data = data2_q;
      end
      default: begin
        rf_we   = 1'b0;
        rf_addr = 3'd0;
        rf_data = 8'd0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight write or evaluation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr1_q <= 3'd0;
      addr2_q <= 3'd0;
      data1_q <= 8'd0;
      data2_q <= 8'd0;
      dual_q  <= 1'b0;
      ex_a_q  <= 8'd0;
      ex_b_q  <= 8'd0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      dual_q  <= dual_d;
      ex_a_q  <= ex_a_d;
      ex_b_q  <= ex_b_d;
      total_q <= total_d;
    end
  end

  assign bus.wt_ready    = idle;
  assign bus.smp_ready   = idle & ~bus.wt_valid;
  assign bus.rf_we       = rf_we;
  assign bus.rf_addr     = rf_addr;
  assign bus.rf_data     = rf_data;
  assign bus.ex_start    = (state_q == START);
  assign bus.ex_a        = ex_a_q;
  assign bus.ex_b        = ex_b_q;
  assign bus.total_steps = total_q;
  assign bus.busy        = ~idle;
  assign bus.dbg_state   = state_q;

endmodule
